// File: rtl/cavlc_pkg.sv
// Shared constants and types for the CAVLC bit packer and its helpers.
//   WORD_W : output word width
//   BUF_W  : accumulator width, must hold WORD_W-1 leftover bits plus a 127-bit code
//   FILL_W : width of the accumulator fill counter (0..158)
package cavlc_pkg;

  localparam int WORD_W = 32;
  localparam int BUF_W  = 160;
  localparam int FILL_W = 8;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } packer_state_t;

endpackage

// File: rtl/cavlc_bit_packer_if.sv
// Code-in / word-out handshake bundle for the CAVLC bit packer.
//   master : upstream code source and downstream word sink (drives inputs)
//   slave  : the packer (drives ready, word and status outputs)
interface cavlc_bit_packer_if #(
  parameter int WORD_W = cavlc_pkg::WORD_W,
  parameter int CNT_W  = 16
);

  logic              code_valid_i;
  logic              code_ready_o;
  logic [127:0]      code_i;
  logic [6:0]        code_bit_i;
  logic              flush_i;
  logic              word_valid_o;
  logic              word_ready_i;
  logic [WORD_W-1:0] word_o;
  logic              word_last_o;
  logic              flush_done_o;
  logic [CNT_W-1:0]  word_count_o;

  modport master (
    output code_valid_i, code_i, code_bit_i, flush_i, word_ready_i,
    input  code_ready_o, word_valid_o, word_o, word_last_o, flush_done_o, word_count_o
  );

  modport slave (
    input  code_valid_i, code_i, code_bit_i, flush_i, word_ready_i,
    output code_ready_o, word_valid_o, word_o, word_last_o, flush_done_o, word_count_o
  );

endinterface

// File: rtl/cavlc_align_shift.sv
// Masks a right-aligned code to its length and places it in an MSB-aligned
// accumulator image directly below the bits already held.
//   code    : 128-bit code, right-aligned
//   len     : valid code length, 0..127
//   fill    : bits already occupied at the top of the accumulator
//   aligned : masked code shifted to offset BUF_W - fill - len
module cavlc_align_shift #(
  parameter int BUF_W  = cavlc_pkg::BUF_W,
  parameter int FILL_W = cavlc_pkg::FILL_W
) (
  input  logic [127:0]      code,
  input  logic [6:0]        len,
  input  logic [FILL_W-1:0] fill,
  output logic [BUF_W-1:0]  aligned
);

  logic [127:0]      mask;
  logic [FILL_W-1:0] sh;

  // A shift by 128 yields zero, so len = 0 needs no special case.
  assign mask    = {128{1'b1}} >> (8'd128 - {1'b0, len});
  assign sh      = FILL_W'(BUF_W) - fill - FILL_W'(len);
  assign aligned = {{(BUF_W-128){1'b0}}, code & mask} << sh;

endmodule

// File: rtl/cavlc_bit_packer.sv
// Packs variable-length CAVLC block codes into a gap-free MSB-first stream of
// WORD_W-bit words; zero-pads and flushes the final partial word on request.
//   clk, rst    : clock, synchronous active-high reset
//   h264_reset  : synchronous per-frame clear, same effect as rst
//   bus (slave) : code input handshake, word output handshake, flush control,
//                 flush_done pulse and handshaken-word counter
//
// state | meaning
// ------+-----------------------------------------------------------
// ACCUM | accept codes while fill < WORD_W, emit full words otherwise
// FLUSH | no input; emit remaining bits, last word zero-padded
// DONE  | one-cycle flush_done pulse, then back to ACCUM
module cavlc_bit_packer #(
  parameter int WORD_W = cavlc_pkg::WORD_W,
  parameter int BUF_W  = cavlc_pkg::BUF_W,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 h264_reset,
  cavlc_bit_packer_if.slave    bus
);

  import cavlc_pkg::*;

  localparam logic [FILL_W-1:0] WORD_F = FILL_W'(WORD_W);

  packer_state_t     state_q, state_d;
  logic [BUF_W-1:0]  acc_q;
  logic [FILL_W-1:0] fill_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BUF_W-1:0]  aligned;

  logic code_ready, word_valid, word_last, flush_done;
  logic accept, pop;

  cavlc_align_shift #(.BUF_W(BUF_W), .FILL_W(FILL_W)) u_align (
    .code    (bus.code_i),
    .len     (bus.code_bit_i),
    .fill    (fill_q),
    .aligned (aligned)
  );

  assign accept = bus.code_valid_i & code_ready;
  assign pop    = word_valid & bus.word_ready_i;

  always_comb begin
    state_d    = state_q;
    code_ready = 1'b0;
    word_valid = 1'b0;
    word_last  = 1'b0;
    flush_done = 1'b0;
    unique case (state_q)
      ACCUM: begin
        code_ready = (fill_q < WORD_F);
        word_valid = (fill_q >= WORD_F);
        if (bus.flush_i) state_d = FLUSH;
      end
      FLUSH: begin
        word_valid = (fill_q != '0);
        word_last  = (fill_q <= WORD_F);
        if (fill_q == '0 || (pop && word_last)) state_d = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_d    = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || h264_reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // accept and pop can never coincide: ready and valid are exclusive
      if (accept) begin
        acc_q  <= acc_q | aligned;
        fill_q <= fill_q + FILL_W'(bus.code_bit_i);
      end else if (pop) begin
        acc_q  <= acc_q << WORD_W;
        fill_q <= (fill_q > WORD_F) ? fill_q - WORD_F : '0;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.code_ready_o = code_ready;
  assign bus.word_valid_o = word_valid;
  assign bus.word_last_o  = word_last;
  assign bus.flush_done_o = flush_done;
  assign bus.word_o       = acc_q[BUF_W-1 -: WORD_W];
  assign bus.word_count_o = cnt_q;

endmodule

// File: tb/tb_cavlc_bit_packer.sv
// Directed self-checking bench for cavlc_bit_packer.
module tb_cavlc_bit_packer;

  logic clk = 1'b0;
  logic rst;
  logic h264_reset;

  cavlc_bit_packer_if bus ();

  cavlc_bit_packer dut (
    .clk        (clk),
    .rst        (rst),
    .h264_reset (h264_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] ONES = {128{1'b1}};

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_code(input logic [127:0] c, input logic [6:0] len);
    bit hs = 1'b0;
    bus.code_i       = c;
    bus.code_bit_i   = len;
    bus.code_valid_i = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      hs = bus.code_ready_o;
      tick();
    end
    bus.code_valid_i = 1'b0;
    chk_eq("code_handshake", 64'(hs), 64'd1);
  endtask

  task automatic pop_word(input string tag, input logic [31:0] exp_w, input logic exp_last);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.word_valid_o) begin
        seen = 1'b1;
        chk_eq({tag, "_word"}, 64'(bus.word_o), 64'(exp_w));
        chk_eq({tag, "_last"}, 64'(bus.word_last_o), 64'(exp_last));
        bus.word_ready_i = 1'b1;
      end
      tick();
    end
    bus.word_ready_i = 1'b0;
    chk_eq({tag, "_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic pulse_flush();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit saw_done;
    rst              = 1'b1;
    h264_reset       = 1'b0;
    bus.code_valid_i = 1'b0;
    bus.code_i       = '0;
    bus.code_bit_i   = '0;
    bus.flush_i      = 1'b0;
    bus.word_ready_i = 1'b0;

    // reset
    do_reset();
    chk_eq("rst_ready", 64'(bus.code_ready_o), 64'd1);
    chk_eq("rst_valid", 64'(bus.word_valid_o), 64'd0);
    chk_eq("rst_count", 64'(bus.word_count_o), 64'd0);
    chk_eq("rst_word",  64'(bus.word_o),       64'd0);
    chk_eq("rst_last",  64'(bus.word_last_o),  64'd0);
    chk_eq("rst_done",  64'(bus.flush_done_o), 64'd0);

    // exact word: 101 followed by 29 ones
    send_code(128'h5, 7'd3);
    chk_eq("ex_no_word_yet", 64'(bus.word_valid_o), 64'd0);
    send_code(128'h1FFF_FFFF, 7'd29);
    chk_eq("ex_latency_valid", 64'(bus.word_valid_o), 64'd1);
    chk_eq("ex_ready_low",     64'(bus.code_ready_o), 64'd0);
    pop_word("ex", 32'hBFFF_FFFF, 1'b0);
    chk_eq("ex_ready_back", 64'(bus.code_ready_o), 64'd1);
    chk_eq("ex_empty",      64'(bus.word_valid_o), 64'd0);
    chk_eq("ex_count",      64'(bus.word_count_o), 64'd1);

    // max code plus flush
    do_reset();
    send_code(ONES, 7'd127);
    for (int i = 0; i < 3; i++) begin
      chk_eq("max_ready_low", 64'(bus.code_ready_o), 64'd0);
      pop_word("max", 32'hFFFF_FFFF, 1'b0);
    end
    chk_eq("max_ready_back", 64'(bus.code_ready_o), 64'd1);
    chk_eq("max_no_word",    64'(bus.word_valid_o), 64'd0);
    pulse_flush();
    pop_word("max_flush", 32'hFFFF_FFFE, 1'b1);
    chk_eq("max_done",      64'(bus.flush_done_o), 64'd1);
    chk_eq("max_count",     64'(bus.word_count_o), 64'd4);
    tick();
    chk_eq("max_done_drop", 64'(bus.flush_done_o), 64'd0);
    chk_eq("max_ready_acc", 64'(bus.code_ready_o), 64'd1);

    // masking, zero-length code, empty flush
    do_reset();
    send_code(ONES, 7'd0);
    chk_eq("zero_len_valid", 64'(bus.word_valid_o), 64'd0);
    send_code(ONES, 7'd4);
    pulse_flush();
    pop_word("mask", 32'hF000_0000, 1'b1);
    chk_eq("mask_done", 64'(bus.flush_done_o), 64'd1);
    tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk_eq("empty_flush_no_done1", 64'(bus.flush_done_o), 64'd0);
    chk_eq("empty_flush_no_word",  64'(bus.word_valid_o), 64'd0);
    tick();
    chk_eq("empty_flush_done",     64'(bus.flush_done_o), 64'd1);
    chk_eq("empty_flush_count",    64'(bus.word_count_o), 64'd1);
    tick();

    // backpressure
    do_reset();
    send_code(128'h1234_5678, 7'd32);
    for (int i = 0; i < 5; i++) begin
      chk_eq("bp_valid", 64'(bus.word_valid_o), 64'd1);
      chk_eq("bp_word",  64'(bus.word_o),       64'h1234_5678);
      chk_eq("bp_last",  64'(bus.word_last_o),  64'd0);
      chk_eq("bp_ready", 64'(bus.code_ready_o), 64'd0);
      chk_eq("bp_count", 64'(bus.word_count_o), 64'd0);
      tick();
    end
    pop_word("bp", 32'h1234_5678, 1'b0);
    chk_eq("bp_count_after", 64'(bus.word_count_o), 64'd1);

    // mid-flush abort with 40 bits buffered
    do_reset();
    send_code(128'hAB_CDEF_0123, 7'd40);
    pulse_flush();
    chk_eq("abort_pre_valid", 64'(bus.word_valid_o), 64'd1);
    chk_eq("abort_pre_last",  64'(bus.word_last_o),  64'd0);
    chk_eq("abort_pre_word",  64'(bus.word_o),       64'hABCD_EF01);
    h264_reset = 1'b1;
    tick();
    h264_reset = 1'b0;
    chk_eq("abort_valid", 64'(bus.word_valid_o), 64'd0);
    chk_eq("abort_count", 64'(bus.word_count_o), 64'd0);
    chk_eq("abort_ready", 64'(bus.code_ready_o), 64'd1);
    saw_done = bus.flush_done_o;
    for (int i = 0; i < 4; i++) begin
      tick();
      saw_done |= bus.flush_done_o;
    end
    chk_eq("abort_no_done", 64'(saw_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
